bf_result_streamer: RTL and testbench



---
 rtl/bf_result_streamer.sv | 154 +++++++++++++++
 tb/tb_bf_result_streamer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_result_streamer.sv
// bf_result_streamer: after Finish, walks the output memory and streams every distance entry over valid/ready.
// Latency: the first entry is valid 1 cycle after entering STREAM; 1 entry/cycle with out_ready high.
// Backpressure: out_ready low holds the presented entry stable and freezes rd_ptr; neg_cycle aborts to NEG.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   finish, neg_cycle        level status from the bellmanford engine
//   mem_addr, mem_data       combinational-read port of the output memory
//   out_valid/out_ready      stream handshake; out_data, out_index, out_inf, out_last travel with it
//   busy, done, neg_flag     status: streaming, complete/aborted, aborted on negative cycle
// Optional: define BF_RESULT_CHECKSUM_EN to add checksum (sum of reachable distances)
//           and reach_cnt (number of reachable entries) outputs.
module bf_result_streamer #(
    parameter int                ADDR_W  = 13,
    parameter int                DATA_W  = 16,
    parameter int                DEPTH   = 8192,
    parameter logic [DATA_W-1:0] INF_VAL = {DATA_W{1'b1}}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     finish,
    input  logic                     neg_cycle,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_inf,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     neg_flag
`ifdef BF_RESULT_CHECKSUM_EN
    ,
    output logic [DATA_W+ADDR_W-1:0] checksum,
    output logic [ADDR_W:0]          reach_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE,
        S_NEG
    } state_t;

    // rd_ptr carries one extra bit so that DEPTH == 2^ADDR_W terminates instead of wrapping.
    localparam logic [ADDR_W:0]   DEPTH_P  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t          state;
    logic [ADDR_W:0] rd_ptr;
    logic            handshake;
    logic            load;
    logic            start;

    assign mem_addr  = rd_ptr[ADDR_W-1:0];
    assign handshake = out_valid && out_ready;
    // Refill the output register when it is empty or being drained this cycle.
    assign load      = (state == S_STREAM) && (!out_valid || out_ready) && (rd_ptr < DEPTH_P);
    assign start     = (state == S_IDLE) && !neg_cycle && finish;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_inf   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            neg_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (neg_cycle) begin
                        state    <= S_NEG;
                        done     <= 1'b1;
                        neg_flag <= 1'b1;
                    end else if (finish) begin
                        state  <= S_STREAM;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (neg_cycle) begin
                        // Abort: a presented but unaccepted entry is dropped.
                        state     <= S_NEG;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        neg_flag  <= 1'b1;
                    end else if (handshake && out_last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (load) begin
                        out_data  <= mem_data;
                        out_index <= rd_ptr[ADDR_W-1:0];
                        out_inf   <= (mem_data == INF_VAL);
                        out_last  <= (rd_ptr[ADDR_W-1:0] == LAST_IDX);
                        out_valid <= 1'b1;
                        rd_ptr    <= rd_ptr + 1'b1;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (neg_cycle) begin
                        state    <= S_NEG;
                        neg_flag <= 1'b1;
                    end else if (!finish) begin
                        // Requiring finish low here stops a held finish from restarting the stream.
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                S_NEG: begin
                    out_valid <= 1'b0;
                    if (!neg_cycle && !finish) begin
                        state    <= S_IDLE;
                        done     <= 1'b0;
                        neg_flag <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BF_RESULT_CHECKSUM_EN
    // Accumulates every accepted reachable entry; cleared only at the start of a new stream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum  <= '0;
            reach_cnt <= '0;
        end else if (start) begin
            checksum  <= '0;
            reach_cnt <= '0;
        end else if (handshake && !out_inf) begin
            checksum  <= checksum + {{ADDR_W{1'b0}}, out_data};
            reach_cnt <= reach_cnt + (ADDR_W + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bf_result_streamer.sv
module tb_bf_result_streamer;

    localparam logic [15:0] INF = 16'hFFFF;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // DEPTH=8 instance (DEPTH == 2^ADDR_W)
    logic        finish, neg_cycle, out_ready;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic        out_valid, out_inf, out_last, busy, done, neg_flag;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic [15:0] mem [8];
    assign mem_data = mem[mem_addr];

    // DEPTH=1 instance
    logic        finish1, neg_cycle1, out_ready1;
    logic [0:0]  mem_addr1;
    logic [15:0] mem_data1;
    logic        out_valid1, out_inf1, out_last1, busy1, done1, neg_flag1;
    logic [15:0] out_data1;
    logic [0:0]  out_index1;
    assign mem_data1 = INF;

`ifdef BF_RESULT_CHECKSUM_EN
    logic [18:0] checksum;
    logic [3:0]  reach_cnt;
    logic [16:0] checksum1;
    logic [1:0]  reach_cnt1;
`endif

    bf_result_streamer #(.ADDR_W(3), .DATA_W(16), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .finish(finish), .neg_cycle(neg_cycle),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_inf(out_inf), .out_last(out_last),
        .busy(busy), .done(done), .neg_flag(neg_flag)
`ifdef BF_RESULT_CHECKSUM_EN
        , .checksum(checksum), .reach_cnt(reach_cnt)
`endif
    );

    bf_result_streamer #(.ADDR_W(1), .DATA_W(16), .DEPTH(1)) dut1 (
        .clock(clock), .reset(reset), .finish(finish1), .neg_cycle(neg_cycle1),
        .mem_addr(mem_addr1), .mem_data(mem_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_index(out_index1), .out_inf(out_inf1), .out_last(out_last1),
        .busy(busy1), .done(done1), .neg_flag(neg_flag1)
`ifdef BF_RESULT_CHECKSUM_EN
        , .checksum(checksum1), .reach_cnt(reach_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the expected stream is simply mem[0..7] in order, INF flagged, last at index 7.
    // mode 0: ready always 1; mode 1: ready pattern 1,0,0 repeating; mode 2: random ready.
    task automatic run_stream(input int mode, input bit hold_finish);
        int          nxt = 0;
        int          cyc = 0;
        int          pat = 0;
        logic [63:0] exp_sum = 0;
        logic [63:0] exp_cnt = 0;
        bit          stalled = 0;
        logic [15:0] s_data = '0;
        logic [2:0]  s_idx = '0;
        logic        s_inf = 1'b0;
        logic        s_last = 1'b0;
        logic [15:0] ev;

        @(negedge clock);
        finish    = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        if (!hold_finish) finish = 1'b0;
        chk("busy_on_entry", 64'(busy), 64'd1);
        chk("valid_on_entry", 64'(out_valid), 64'd0);
`ifdef BF_RESULT_CHECKSUM_EN
        chk("checksum_cleared", 64'(checksum), 64'd0);
        chk("reach_cleared", 64'(reach_cnt), 64'd0);
`endif
        while (nxt < 8 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            chk("busy_stream", 64'(busy), 64'd1);
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(s_data));
                chk("stall_index", 64'(out_index), 64'(s_idx));
                chk("stall_flags", 64'({out_inf, out_last}), 64'({s_inf, s_last}));
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (pat % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            pat++;
            if (out_valid && out_ready) begin
                ev = mem[3'(nxt)];
                chk("index", 64'(out_index), 64'(nxt));
                chk("data", 64'(out_data), 64'(ev));
                chk("inf", 64'(out_inf), 64'(ev == INF));
                chk("last", 64'(out_last), 64'(nxt == 7));
                if (mode == 0) chk("cycle", 64'(cyc), 64'(nxt + 1));
                if (ev != INF) begin
                    exp_sum += 64'(ev);
                    exp_cnt += 64'd1;
                end
                nxt++;
            end
            stalled = out_valid && !out_ready;
            s_data = out_data;
            s_idx  = out_index;
            s_inf  = out_inf;
            s_last = out_last;
        end
        if (nxt < 8) chk("stream_timeout", 64'(nxt), 64'd8);
        @(negedge clock);
        out_ready = 1'b0;
        chk("done_after_last", 64'(done), 64'd1);
        chk("busy_after_last", 64'(busy), 64'd0);
        chk("valid_after_last", 64'(out_valid), 64'd0);
        chk("negflag_after_last", 64'(neg_flag), 64'd0);
`ifdef BF_RESULT_CHECKSUM_EN
        chk("checksum", 64'(checksum), exp_sum);
        chk("reach_cnt", 64'(reach_cnt), exp_cnt);
`endif
        if (hold_finish) begin
            repeat (3) @(negedge clock);
            chk("held_finish_done", 64'(done), 64'd1);
            chk("held_finish_busy", 64'(busy), 64'd0);
            chk("held_finish_valid", 64'(out_valid), 64'd0);
            finish = 1'b0;
        end
        @(negedge clock);
        chk("done_clears", 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] part_sum;
        reset = 1'b1;
        finish = 0; neg_cycle = 0; out_ready = 0;
        finish1 = 0; neg_cycle1 = 0; out_ready1 = 0;
        mem = '{16'd0, 16'd3, 16'hFFFF, 16'd7, 16'd1, 16'hFFFF, 16'd2, 16'd9};
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_status", 64'({busy, done, neg_flag}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'({out_data, out_index, out_inf, out_last}), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Full-rate stream of the reference memory
        run_stream(0, 1'b0);
`ifdef BF_RESULT_CHECKSUM_EN
        chk("checksum_22", 64'(checksum), 64'd22);
        chk("reach_6", 64'(reach_cnt), 64'd6);
`endif
        // Backpressure pattern 1,0,0 and finish held high past DONE
        run_stream(1, 1'b0);
        run_stream(0, 1'b1);

        // neg_cycle and finish together: NEG wins, no entries
        @(negedge clock);
        finish = 1'b1; neg_cycle = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("neg_same_valid", 64'(out_valid), 64'd0);
            chk("neg_same_flags", 64'({neg_flag, done, busy}), 64'b110);
        end
        finish = 1'b0;
        @(negedge clock);
        chk("neg_holds", 64'({neg_flag, done}), 64'b11);
        neg_cycle = 1'b0;
        @(negedge clock);
        chk("neg_exit", 64'({neg_flag, done}), 64'b00);

        // neg_cycle with index 4 pending after index 3 accepted
        @(negedge clock);
        finish = 1'b1;
        @(negedge clock);
        finish = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_index == 3'd4) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("reach_index4", 64'(out_valid && out_index == 3'd4), 64'd1);
        out_ready = 1'b0;
        neg_cycle = 1'b1;
        part_sum = 64'd0 + 64'd3 + 64'd7;
        repeat (3) begin
            @(negedge clock);
            chk("abort_valid", 64'(out_valid), 64'd0);
            chk("abort_flags", 64'({neg_flag, done, busy}), 64'b110);
        end
`ifdef BF_RESULT_CHECKSUM_EN
        chk("abort_checksum", 64'(checksum), part_sum);
        chk("abort_reach", 64'(reach_cnt), 64'd3);
`endif
        neg_cycle = 1'b0;
        @(negedge clock);
        chk("abort_exit", 64'({neg_flag, done}), 64'b00);

        // Asynchronous reset with index 5 presented
        @(negedge clock);
        finish = 1'b1;
        @(negedge clock);
        finish = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_index == 3'd5) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("reach_index5", 64'(out_valid && out_index == 3'd5), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_status", 64'({busy, done, neg_flag}), 64'd0);
        out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_stream(0, 1'b0);

        // Random memory contents and random backpressure against the reference
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++)
                mem[i] = ($urandom_range(0, 2) == 0) ? INF : 16'($urandom);
            run_stream(2, 1'($urandom_range(0, 1)));
        end

        // DEPTH=1 instance, single unreachable entry
        @(negedge clock);
        finish1 = 1'b1;
        out_ready1 = 1'b1;
        @(negedge clock);
        finish1 = 1'b0;
        chk("d1_busy", 64'(busy1), 64'd1);
        chk("d1_valid_entry", 64'(out_valid1), 64'd0);
        @(negedge clock);
        chk("d1_valid", 64'(out_valid1), 64'd1);
        chk("d1_entry", 64'({out_index1, out_inf1, out_last1}), 64'b011);
        chk("d1_data", 64'(out_data1), 64'hFFFF);
        @(negedge clock);
        chk("d1_done", 64'({done1, busy1, out_valid1, neg_flag1}), 64'b1000);
`ifdef BF_RESULT_CHECKSUM_EN
        chk("d1_checksum", 64'(checksum1), 64'd0);
        chk("d1_reach", 64'(reach_cnt1), 64'd0);
`endif
        out_ready1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
